// File: rtl/xor_share_arb.sv
// xor_share_arb: one WIDTH-bit XOR unit shared by four requesters under
// round-robin arbitration. A granted requester's operands are captured on the
// grant edge and held in a result register until the downstream handshake.
// Optional feature: define XOR_SHARE_ARB_PARITY_EN to add output res_parity,
// the registered XOR-reduction of res_data.
module xor_share_arb #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  input  logic                 res_ready,
  output logic [3:0]           gnt,
  output logic                 res_valid,
  output logic [WIDTH-1:0]     res_data,
  output logic [1:0]           res_id
`ifdef XOR_SHARE_ARB_PARITY_EN
  ,
  output logic                 res_parity
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         ptr, ptr_nxt;
  logic [1:0]         scan_base;
  logic [1:0]         scan_idx;
  logic [1:0]         win;
  logic               win_found;
  logic               handshake;
  logic               do_grant;
  logic [WIDTH-1:0]   xor_res;
  logic [3:0]         gnt_nxt;
  logic               res_valid_nxt;
  logic [WIDTH-1:0]   res_data_nxt;
  logic [1:0]         res_id_nxt;

  // Round-robin winner search; on a handshake the scan already starts just past
  // the requester being retired so back-to-back grants rotate fairly.
  always_comb begin
    handshake = (state == BUSY) && res_valid && res_ready;
    scan_base = handshake ? (res_id + 2'd1) : ptr;
    win_found = 1'b0;
    win       = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = scan_base + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win       = scan_idx;
      end
    end
  end

  // The shared XOR unit, fed by the winner's operand slices.
  always_comb begin
    xor_res = '0;
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) begin
        xor_res = a_in[i*WIDTH +: WIDTH] ^ b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and output logic; a grant always lands the block in BUSY.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_nxt       = 4'b0000;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    res_id_nxt    = res_id;
    do_grant      = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          do_grant = 1'b1;
        end
      end
      BUSY: begin
        if (handshake) begin
          ptr_nxt = scan_base;
          if (win_found) begin
            do_grant = 1'b1;
          end else begin
            res_valid_nxt = 1'b0;
            state_nxt     = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (do_grant) begin
      gnt_nxt       = 4'b0001 << win;
      res_valid_nxt = 1'b1;
      res_data_nxt  = xor_res;
      res_id_nxt    = win;
      state_nxt     = BUSY;
    end
  end

  // State, pointer and result registers; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      gnt        <= 4'b0000;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 2'd0;
`ifdef XOR_SHARE_ARB_PARITY_EN
      res_parity <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      gnt        <= gnt_nxt;
      res_valid  <= res_valid_nxt;
      res_data   <= res_data_nxt;
      res_id     <= res_id_nxt;
`ifdef XOR_SHARE_ARB_PARITY_EN
      res_parity <= ^res_data_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_xor_share_arb.sv
// tb_xor_share_arb: directed self-checking bench for xor_share_arb (WIDTH=8).
// Compile with XOR_SHARE_ARB_PARITY_EN defined to also check res_parity.
module tb_xor_share_arb;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_in;
  logic [4*WIDTH-1:0] b_in;
  logic               res_ready;
  logic [3:0]         gnt;
  logic               res_valid;
  logic [WIDTH-1:0]   res_data;
  logic [1:0]         res_id;
`ifdef XOR_SHARE_ARB_PARITY_EN
  logic               res_parity;
`endif

  int checks = 0;
  int errors = 0;

  // Requester operands: results are AA, 26, C3, FF for requesters 0..3.
  localparam logic [4*WIDTH-1:0] A_BASE = {8'hF0, 8'h3C, 8'h12, 8'hA5};
  localparam logic [4*WIDTH-1:0] B_BASE = {8'h0F, 8'hFF, 8'h34, 8'h0F};

  xor_share_arb #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_ready (res_ready),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id)
`ifdef XOR_SHARE_ARB_PARITY_EN
    ,
    .res_parity(res_parity)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [3:0] e_gnt,
                            input logic e_valid, input logic [7:0] e_data,
                            input logic [1:0] e_id);
    check_output({tag, " gnt"}, 32'(gnt), 32'(e_gnt));
    check_output({tag, " valid"}, 32'(res_valid), 32'(e_valid));
    check_output({tag, " data"}, 32'(res_data), 32'(e_data));
    check_output({tag, " id"}, 32'(res_id), 32'(e_id));
  endtask

  task automatic expect_idle(input string tag);
    check_output({tag, " gnt"}, 32'(gnt), 32'd0);
    check_output({tag, " valid"}, 32'(res_valid), 32'd0);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    req       = 4'b0000;
    res_ready = 1'b0;
    a_in      = A_BASE;
    b_in      = B_BASE;
    $display("[TB] start");

    // Reset values
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_all("reset", 4'b0000, 1'b0, 8'h00, 2'd0);
    #2 rst_n = 1'b1;

    // Round-robin with all four requesting and downstream always ready
    res_ready = 1'b1;
    req       = 4'b1111;
    tick(); expect_all("rr0", 4'b0001, 1'b1, 8'hAA, 2'd0);
    tick(); expect_all("rr1", 4'b0010, 1'b1, 8'h26, 2'd1);
    tick(); expect_all("rr2", 4'b0100, 1'b1, 8'hC3, 2'd2);
    tick(); expect_all("rr3", 4'b1000, 1'b1, 8'hFF, 2'd3);
    tick(); expect_all("rr4", 4'b0001, 1'b1, 8'hAA, 2'd0);
    req = 4'b0000;
    tick(); expect_idle("rr_end");

    // Single request from requester 0 (ptr is now 1)
    req = 4'b0001;
    tick(); expect_all("single", 4'b0001, 1'b1, 8'hAA, 2'd0);
`ifdef XOR_SHARE_ARB_PARITY_EN
    check_output("single parity", 32'(res_parity), 32'd0);
`endif
    req = 4'b0000;
    tick(); expect_idle("single_end");

    // Pointer skip: ptr=1, requesters 3 and 0 pending
    req = 4'b1001;
    tick(); expect_all("skip3", 4'b1000, 1'b1, 8'hFF, 2'd3);
    req = 4'b0001;
    tick(); expect_all("skip0", 4'b0001, 1'b1, 8'hAA, 2'd0);
    req = 4'b0000;
    tick(); expect_idle("skip_end");

    // Backpressure: requester 2 held while operands change, 3 waiting
    res_ready = 1'b0;
    req       = 4'b0100;
    tick(); expect_all("bp_gnt", 4'b0100, 1'b1, 8'hC3, 2'd2);
    req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      a_in = A_BASE + 32'(c + 1) * 32'h0101_0101;
      b_in = B_BASE ^ (32'(c + 1) * 32'h1111_1111);
      tick(); expect_all("bp_hold", 4'b0000, 1'b1, 8'hC3, 2'd2);
    end
    a_in      = A_BASE;
    b_in      = B_BASE;
    res_ready = 1'b1;
    tick(); expect_all("bp_next", 4'b1000, 1'b1, 8'hFF, 2'd3);
    req = 4'b0000;
    tick(); expect_idle("bp_end");

    // Withdrawal: requester 1 pulses while the result is blocked
    res_ready = 1'b0;
    req       = 4'b0001;
    tick(); expect_all("wd_gnt", 4'b0001, 1'b1, 8'hAA, 2'd0);
    req = 4'b0010;
    tick(); expect_all("wd_pulse", 4'b0000, 1'b1, 8'hAA, 2'd0);
    req = 4'b0000;
    tick(); expect_all("wd_wait", 4'b0000, 1'b1, 8'hAA, 2'd0);
    res_ready = 1'b1;
    tick(); expect_idle("wd_hs");
    tick(); expect_idle("wd_after");

    // Reset mid-operation while BUSY (ptr is 1 before reset)
    res_ready = 1'b0;
    req       = 4'b0010;
    tick(); expect_all("rst_busy", 4'b0010, 1'b1, 8'h26, 2'd1);
    req = 4'b0000;
    #3 rst_n = 1'b0;
    #1 expect_all("rst_async", 4'b0000, 1'b0, 8'h00, 2'd0);
    #2 rst_n = 1'b1;
    tick(); expect_idle("rst_quiet");
    req = 4'b0100;
    tick(); expect_all("rst_gnt2", 4'b0100, 1'b1, 8'hC3, 2'd2);
    req       = 4'b0000;
    res_ready = 1'b1;
    tick(); expect_idle("rst_hs");

    // Pointer returns to 0 after a second reset: requesters 0 and 1 pending
    #3 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    req       = 4'b0011;
    res_ready = 1'b0;
    tick(); expect_all("rst_ptr", 4'b0001, 1'b1, 8'hAA, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_share_arb.md
XOR_SHARE_ARB -- requirements
Module: xor_share_arb

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous assert, active-low.
REQ-004 req  input  4  Per-requester request, bit i belongs to requester i.
REQ-005 a_in  input  4*WIDTH  Operand A per requester; slice i = a_in[i*WIDTH +: WIDTH].
REQ-006 b_in  input  4*WIDTH  Operand B per requester, same slicing.
REQ-007 gnt  output  4  One-hot grant pulse, registered.
REQ-008 res_valid  output  1  Result available.
REQ-009 res_data  output  WIDTH  Registered XOR result.
REQ-010 res_id  output  2  Index of the requester that owns res_data.
REQ-011 res_ready  input  1  Downstream accepts the result.

Function
REQ-012 The module SHALL share one WIDTH-bit XOR unit among four requesters using round-robin arbitration.
REQ-013 The FSM SHALL have two states, IDLE (no result held) and BUSY (result held, res_valid=1).
REQ-014 Winner selection SHALL scan req starting at index ptr and then ptr+1, ptr+2, ptr+3 (mod 4), choosing the first set bit.
REQ-015 In IDLE with req!=0, at the next edge the block SHALL:
- set gnt to one-hot for the winner for exactly one cycle;
- register res_data = a_in[w] ^ b_in[w] and res_id = w;
- set res_valid = 1;
- go to BUSY.
REQ-016 Operands SHALL be sampled only at the grant edge; later changes SHALL NOT affect res_data.
REQ-017 In BUSY, res_data and res_id SHALL hold stable until res_valid && res_ready is sampled high.
REQ-018 On a BUSY handshake edge, ptr SHALL become res_id+1 (mod 4).
REQ-019 On a BUSY handshake edge with req==0, the block SHALL clear res_valid and go to IDLE.
REQ-020 On a BUSY handshake edge with req!=0, the block SHALL arbitrate on that same edge using the updated ptr, then grant, capture and stay in BUSY (back-to-back, one result per cycle).
REQ-021 gnt SHALL be 0 in every cycle except the cycle following a grant edge; at most one gnt bit SHALL be high.
REQ-022 A requester SHALL keep req high until it sees gnt. If req is still high after its gnt, the block SHALL treat it as a new request at the lowest round-robin priority.
REQ-023 In BUSY without res_ready, pending requests SHALL wait; no grant SHALL be issued.
REQ-024 A req bit that drops before being granted SHALL be treated as withdrawn, with no error.

Reset
REQ-025 When rst_n is low, the block SHALL immediately force state=IDLE, ptr=0, gnt=0, res_valid=0, res_data=0, res_id=0, independent of clk.
REQ-026 A reset asserted while in BUSY SHALL discard the held result; no grant SHALL occur on the first edge where rst_n is high unless req!=0 is sampled on that edge.

Configuration
REQ-027 Macro XOR_SHARE_ARB_PARITY_EN SHALL control an optional parity output.
REQ-028 With XOR_SHARE_ARB_PARITY_EN defined, the block SHALL add output res_parity (1 bit) equal to the XOR-reduction of res_data, registered with res_data and reset to 0.
REQ-029 Without XOR_SHARE_ARB_PARITY_EN, port res_parity SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Single request: WIDTH=8, req=0001, a0=8'hA5, b0=8'h0F, res_ready=1 -> gnt=0001 for one cycle, res_data=8'hAA, res_id=0, res_valid for 1 cycle, parity (if enabled)=0.
REQ-031 Round-robin: req=1111 held, res_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles, res_valid continuously 1.
REQ-032 Backpressure: grant requester 2 (a=8'h3C, b=8'hFF), hold res_ready=0 for 5 cycles while changing a_in/b_in -> res_data stays 8'hC3, res_id=2, gnt stays 0; raise res_ready -> next grant goes to requester 3 if pending.
REQ-033 Pointer skip: ptr=1 and req=1001 -> requester 3 is granted first, then requester 0.
REQ-034 Reset mid-operation: in BUSY with res_valid=1, pull rst_n low between edges -> res_valid, gnt, res_data go to 0 immediately; after release, req=0100 -> grant to requester 2 (ptr=0 scan).
REQ-035 Withdrawal: req=0010 pulsed high for one cycle while BUSY and not ready -> after the handshake, no grant to requester 1 and the block returns to IDLE.
